// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the memory-side refill controller.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   state_t       - controller FSM states (IDLE, READ, DRAIN)
//   WB_DEPTH_DEF  - default write-back buffer depth
//   word_addr()   - strips the byte offset [1:0] from an address
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int WB_DEPTH_DEF = 4;

    // word_addr works on a fixed maximum width so it can serve any ADDR_W up
    // to 64; callers zero-extend, which keeps compares between two equally
    // sized addresses exact.
    localparam int MAX_ADDR_W  = 64;
    localparam int WORD_ADDR_W = MAX_ADDR_W - 2;

    function automatic logic [WORD_ADDR_W-1:0] word_addr(input logic [MAX_ADDR_W-1:0] addr);
        return WORD_ADDR_W'(addr >> 2);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Write-back buffer: circular FIFO of dirty victims with newest-first address match.
// Latency: push visible to match in the same cycle, to head/empty after 1 edge.
// Backpressure: none; push while full is dropped (sticky overflow) unless a pop frees a slot.
//
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_push, i_push_addr, i_push_data    new entry (one-cycle pulse)
//   i_pop                               retire head entry
//   i_match_addr -> o_hit, o_hit_data   word-address lookup, newest match wins
//   o_head_addr, o_head_data            oldest entry
//   o_empty                             no entries (from registered count)
//   o_full                              registered: DEPTH entries held
//   o_overflow                          registered, sticky: push dropped while full
module wb_fifo
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = WB_DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_match_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_hit_data,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_overflow;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [PTR_W-1:0]  w_idx;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push  = i_push && (!w_full || w_pop);

    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            if (i_push && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: validity is carried by r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_addr[r_tail] <= i_push_addr;
            r_data[r_tail] <= i_push_data;
        end
    end

    // Walk entries oldest to newest so a later match overrides an earlier one;
    // the entry being pushed this cycle is newer than anything stored.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        w_idx      = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) &&
                (word_addr(MAX_ADDR_W'(r_addr[w_idx])) == word_addr(MAX_ADDR_W'(i_match_addr)))) begin
                o_hit      = 1'b1;
                o_hit_data = r_data[w_idx];
            end
        end
        if (w_push &&
            (word_addr(MAX_ADDR_W'(i_push_addr)) == word_addr(MAX_ADDR_W'(i_match_addr)))) begin
            o_hit      = 1'b1;
            o_hit_data = i_push_data;
        end
    end

    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_empty     = w_empty;
    assign o_full      = r_full;
    assign o_overflow  = r_overflow;

endmodule

// File: rtl/mem_refill_ctrl.sv
// Cache-to-memory controller: serves miss refills, buffers evictions, forwards buffered data.
// Latency: forward hit fill->valid 1 cycle; memory read fill->mem_req 1 cycle, mem_ack->valid 1 cycle.
// Backpressure: memory holds mem_req until mem_ack; cache is never stalled (evictions overflow sticky).
//
// Ports:
//   i_clk, i_rst_n                          clock, async active-low reset
//   i_fill_req, i_fill_addr                 miss request pulse and address
//   o_fill_valid, o_fill_data               refill data pulse
//   i_wb_req, i_wb_addr, i_wb_data          eviction pulse and victim line
//   o_wb_full, o_wb_overflow                buffer full, sticky drop flag
//   o_busy                                  FSM not IDLE or a fill pending
//   o_mem_req/we/addr/wdata                 registered memory request
//   i_mem_ack, i_mem_rdata                  memory completion and read data
module mem_refill_ctrl
    import mem_if_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WB_DEPTH = WB_DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fill_req,
    input  logic [ADDR_W-1:0] i_fill_addr,
    output logic [DATA_W-1:0] o_fill_data,
    output logic              o_fill_valid,
    input  logic              i_wb_req,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic              o_wb_full,
    output logic              o_wb_overflow,
    output logic              o_busy,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_pend_vld;
    logic [ADDR_W-1:0] r_pend_addr;
    logic              w_pend_set;
    logic              w_pend_clr;
    logic              w_pend_vld;
    logic [ADDR_W-1:0] w_pend_addr;
    logic              w_pend_vld_nxt;

    logic              r_fill_valid;
    logic [DATA_W-1:0] r_fill_data;
    logic              r_busy;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_fill_valid_nxt;
    logic [DATA_W-1:0] w_fill_data_nxt;
    logic              w_mem_req_nxt;
    logic              w_mem_we_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic              w_busy_nxt;

    logic              w_pop;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_wb_empty;
    logic              w_wb_full;
    logic              w_wb_overflow;

    // Only one fill may be outstanding; the pending flag stays set through
    // READ, so a second request during READ is ignored as well.
    assign w_pend_set = i_fill_req && !r_pend_vld;

    // A fresh request is evaluated in the cycle it arrives, which is what
    // gives the one-cycle forward-hit and read-issue latency.
    assign w_pend_vld  = r_pend_vld || w_pend_set;
    assign w_pend_addr = r_pend_vld ? r_pend_addr : i_fill_addr;

    wb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WB_DEPTH)
    ) u_wb_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push       (i_wb_req),
        .i_push_addr  (i_wb_addr),
        .i_push_data  (i_wb_data),
        .i_pop        (w_pop),
        .i_match_addr (w_pend_addr),
        .o_hit        (w_hit),
        .o_hit_data   (w_hit_data),
        .o_head_addr  (w_head_addr),
        .o_head_data  (w_head_data),
        .o_empty      (w_wb_empty),
        .o_full       (w_wb_full),
        .o_overflow   (w_wb_overflow)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pend_clr       = 1'b0;
        w_pop            = 1'b0;
        w_fill_valid_nxt = 1'b0;
        w_fill_data_nxt  = r_fill_data;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;

        case (r_state)
            IDLE: begin
                if (w_pend_vld && w_hit) begin
                    w_fill_valid_nxt = 1'b1;
                    w_fill_data_nxt  = w_hit_data;
                    w_pend_clr       = 1'b1;
                end else if (w_pend_vld) begin
                    w_state_nxt    = READ;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = w_pend_addr;
                end else if (!w_wb_empty) begin
                    w_state_nxt     = DRAIN;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = w_head_addr;
                    w_mem_wdata_nxt = w_head_data;
                end
            end
            READ: begin
                if (i_mem_ack) begin
                    w_state_nxt      = IDLE;
                    w_fill_valid_nxt = 1'b1;
                    w_fill_data_nxt  = i_mem_rdata;
                    w_pend_clr       = 1'b1;
                    w_mem_req_nxt    = 1'b0;
                end
            end
            DRAIN: begin
                if (i_mem_ack) begin
                    w_state_nxt   = IDLE;
                    w_pop         = 1'b1;
                    w_mem_req_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    assign w_pend_vld_nxt = w_pend_vld && !w_pend_clr;
    assign w_busy_nxt     = (w_state_nxt != IDLE) || w_pend_vld_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_vld   <= 1'b0;
            r_pend_addr  <= '0;
            r_fill_valid <= 1'b0;
            r_fill_data  <= '0;
            r_busy       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_pend_vld   <= w_pend_vld_nxt;
            if (w_pend_set) begin
                r_pend_addr <= i_fill_addr;
            end
            r_fill_valid <= w_fill_valid_nxt;
            r_fill_data  <= w_fill_data_nxt;
            r_busy       <= w_busy_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
        end
    end

    assign o_fill_valid  = r_fill_valid;
    assign o_fill_data   = r_fill_data;
    assign o_busy        = r_busy;
    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_wb_full     = w_wb_full;
    assign o_wb_overflow = w_wb_overflow;

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Directed self-checking bench for mem_refill_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Each scenario task drives its stimulus and checks its own expected values.
module tb_mem_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fill_req = 1'b0;
    logic [31:0] fill_addr = '0;
    logic [31:0] fill_data;
    logic        fill_valid;
    logic        wb_req = 1'b0;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        wb_full;
    logic        wb_overflow;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_refill_ctrl #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .WB_DEPTH (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_fill_req    (fill_req),
        .i_fill_addr   (fill_addr),
        .o_fill_data   (fill_data),
        .o_fill_valid  (fill_valid),
        .i_wb_req      (wb_req),
        .i_wb_addr     (wb_addr),
        .i_wb_data     (wb_data),
        .o_wb_full     (wb_full),
        .o_wb_overflow (wb_overflow),
        .o_busy        (busy),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_ack     (mem_ack),
        .i_mem_rdata   (mem_rdata)
    );

    // The bench must never issue a second fill while one is outstanding.
    always @(posedge clk) begin
        if (rst_n && fill_req && dut.r_pend_vld) begin
            $display("FAIL fill_protocol pending=1 required=0 at %0t", $time);
            bad++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({fill_data, fill_valid, wb_full, wb_overflow, busy, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            $display("FAIL reset_outputs fv=%b fd=%h full=%b ovf=%b busy=%b req=%b required all 0",
                     fill_valid, fill_data, wb_full, wb_overflow, busy, mem_req);
            bad++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_refill(input logic [31:0] a, input logic [31:0] d);
        fill_req = 1'b1; fill_addr = a;
        tick();
        fill_req = 1'b0;
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== a || busy !== 1'b1) begin
            $display("FAIL refill_issue req=%b we=%b addr=%h busy=%b required 1 0 %h 1", mem_req, mem_we, mem_addr, busy, a);
            bad++;
        end
        tick();
        tick();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== a || fill_valid !== 1'b0) begin
            $display("FAIL refill_hold req=%b addr=%h fv=%b required 1 %h 0", mem_req, mem_addr, fill_valid, a);
            bad++;
        end
        mem_ack = 1'b1; mem_rdata = d;
        tick();
        mem_ack = 1'b0;
        total++;
        if (fill_valid !== 1'b1 || fill_data !== d) begin
            $display("FAIL refill_data fv=%b data=%h required 1 %h", fill_valid, fill_data, d);
            bad++;
        end
        total++;
        if (mem_req !== 1'b0) begin
            $display("FAIL refill_req_drop req=%b required 0", mem_req);
            bad++;
        end
        tick();
        total++;
        if (fill_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL refill_idle fv=%b busy=%b required 0 0", fill_valid, busy);
            bad++;
        end
    endtask

    task automatic test_forwarding();
        // Park a read in flight so both write-backs stay buffered.
        fill_req = 1'b1; fill_addr = 32'h200;
        tick();
        fill_req = 1'b0;
        wb_req = 1'b1; wb_addr = 32'h80; wb_data = 32'h1111_1111;
        tick();
        wb_addr = 32'h80; wb_data = 32'h2222_2222;
        tick();
        wb_req = 1'b0;
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200 || wb_full !== 1'b0) begin
            $display("FAIL fwd_setup req=%b we=%b addr=%h full=%b required 1 0 200 0", mem_req, mem_we, mem_addr, wb_full);
            bad++;
        end
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        tick();
        mem_ack = 1'b0;
        fill_req = 1'b1; fill_addr = 32'h82;
        tick();
        fill_req = 1'b0;
        total++;
        if (fill_valid !== 1'b1 || fill_data !== 32'h2222_2222 || mem_req !== 1'b0) begin
            $display("FAIL fwd_hit fv=%b data=%h req=%b required 1 22222222 0", fill_valid, fill_data, mem_req);
            bad++;
        end
        tick();
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'h1111_1111) begin
            $display("FAIL fwd_drain0 req=%b we=%b addr=%h wdata=%h required 1 1 80 11111111", mem_req, mem_we, mem_addr, mem_wdata);
            bad++;
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h2222_2222) begin
            $display("FAIL fwd_drain1 req=%b we=%b wdata=%h required 1 1 22222222", mem_req, mem_we, mem_wdata);
            bad++;
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        total++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL fwd_end req=%b busy=%b required 0 0", mem_req, busy);
            bad++;
        end
    endtask

    task automatic test_refill_priority();
        logic [31:0] wa [3];
        wa[0] = 32'h300; wa[1] = 32'h304; wa[2] = 32'h308;
        for (int i = 0; i < 3; i++) begin
            wb_req = 1'b1; wb_addr = wa[i]; wb_data = 32'(i + 1);
            tick();
        end
        wb_req = 1'b0;
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h300 || mem_wdata !== 32'h1) begin
            $display("FAIL prio_drain0 req=%b we=%b addr=%h wdata=%h required 1 1 300 1", mem_req, mem_we, mem_addr, mem_wdata);
            bad++;
        end
        fill_req = 1'b1; fill_addr = 32'h100;
        tick();
        fill_req = 1'b0;
        total++;
        if (busy !== 1'b1 || mem_addr !== 32'h300 || mem_req !== 1'b1) begin
            $display("FAIL prio_wait busy=%b addr=%h req=%b required 1 300 1", busy, mem_addr, mem_req);
            bad++;
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total++;
        if (mem_req !== 1'b0) begin
            $display("FAIL prio_gap req=%b required 0", mem_req);
            bad++;
        end
        tick();
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            $display("FAIL prio_read req=%b we=%b addr=%h required 1 0 100", mem_req, mem_we, mem_addr);
            bad++;
        end
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        total++;
        if (fill_valid !== 1'b1 || fill_data !== 32'h0BAD_F00D) begin
            $display("FAIL prio_fill fv=%b data=%h required 1 0badf00d", fill_valid, fill_data);
            bad++;
        end
        for (int i = 1; i < 3; i++) begin
            tick();
            total++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== wa[i] || mem_wdata !== 32'(i + 1)) begin
                $display("FAIL prio_drain%0d req=%b we=%b addr=%h wdata=%h required 1 1 %h %h",
                         i, mem_req, mem_we, mem_addr, mem_wdata, wa[i], i + 1);
                bad++;
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        tick();
        total++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL prio_end req=%b busy=%b required 0 0", mem_req, busy);
            bad++;
        end
    endtask

    task automatic test_full_buffer();
        logic [31:0] ea [4];
        logic [31:0] ed [4];
        ea[0] = 32'h404; ea[1] = 32'h408; ea[2] = 32'h40C; ea[3] = 32'h414;
        ed[0] = 32'hA1;  ed[1] = 32'hA2;  ed[2] = 32'hA3;  ed[3] = 32'hA5;
        for (int i = 0; i < 4; i++) begin
            wb_req = 1'b1; wb_addr = 32'h400 + 32'(4 * i); wb_data = 32'hA0 + 32'(i);
            tick();
        end
        wb_req = 1'b0;
        total++;
        if (wb_full !== 1'b1 || wb_overflow !== 1'b0) begin
            $display("FAIL full_set full=%b ovf=%b required 1 0", wb_full, wb_overflow);
            bad++;
        end
        wb_req = 1'b1; wb_addr = 32'h410; wb_data = 32'hA4;
        tick();
        wb_req = 1'b0;
        total++;
        if (wb_full !== 1'b1 || wb_overflow !== 1'b1) begin
            $display("FAIL full_overflow full=%b ovf=%b required 1 1", wb_full, wb_overflow);
            bad++;
        end
        // Push lands in the same cycle the in-flight drain of 0x400 completes.
        wb_req = 1'b1; wb_addr = 32'h414; wb_data = 32'hA5; mem_ack = 1'b1;
        tick();
        wb_req = 1'b0; mem_ack = 1'b0;
        total++;
        if (wb_full !== 1'b1 || wb_overflow !== 1'b1 || mem_req !== 1'b0) begin
            $display("FAIL full_push_pop full=%b ovf=%b req=%b required 1 1 0", wb_full, wb_overflow, mem_req);
            bad++;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ea[i] || mem_wdata !== ed[i]) begin
                $display("FAIL full_drain%0d req=%b we=%b addr=%h wdata=%h required 1 1 %h %h",
                         i, mem_req, mem_we, mem_addr, mem_wdata, ea[i], ed[i]);
                bad++;
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            if (i == 0) begin
                total++;
                if (wb_full !== 1'b0) begin
                    $display("FAIL full_clear full=%b required 0", wb_full);
                    bad++;
                end
            end
        end
        tick();
        total++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || wb_overflow !== 1'b1) begin
            $display("FAIL full_end req=%b busy=%b ovf=%b required 0 0 1", mem_req, busy, wb_overflow);
            bad++;
        end
    endtask

    task automatic test_same_cycle_hazard();
        wb_req = 1'b1; wb_addr = 32'hC0; wb_data = 32'h5;
        fill_req = 1'b1; fill_addr = 32'hC0;
        tick();
        wb_req = 1'b0; fill_req = 1'b0;
        total++;
        if (fill_valid !== 1'b1 || fill_data !== 32'h5 || mem_req !== 1'b0) begin
            $display("FAIL hazard_fwd fv=%b data=%h req=%b required 1 5 0", fill_valid, fill_data, mem_req);
            bad++;
        end
        tick();
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'hC0) begin
            $display("FAIL hazard_no_read req=%b we=%b addr=%h required 1 1 c0", mem_req, mem_we, mem_addr);
            bad++;
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_txn();
        fill_req = 1'b1; fill_addr = 32'h40;
        tick();
        fill_req = 1'b0;
        wb_req = 1'b1; wb_addr = 32'h500; wb_data = 32'h77;
        tick();
        wb_req = 1'b0;
        total++;
        if (mem_req !== 1'b1) begin
            $display("FAIL rst_pre req=%b required 1", mem_req);
            bad++;
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({fill_data, fill_valid, wb_full, wb_overflow, busy, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            $display("FAIL rst_async req=%b busy=%b ovf=%b addr=%h fv=%b required all 0",
                     mem_req, busy, wb_overflow, mem_addr, fill_valid);
            bad++;
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || wb_full !== 1'b0) begin
            $display("FAIL rst_buffer_empty req=%b busy=%b full=%b required 0 0 0", mem_req, busy, wb_full);
            bad++;
        end
        test_refill(32'h40, 32'hDEAD_BEEF);
    endtask

    initial begin
        test_reset();
        test_refill(32'h40, 32'hDEAD_BEEF);
        test_forwarding();
        test_refill_priority();
        test_full_buffer();
        test_same_cycle_hazard();
        test_reset_mid_txn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
